// File: rtl/wall_report_scheduler.sv
// Wall report scheduler: debounces the three ultrasonic wall flags, and sends
// a redundant, parity-protected frame whenever the debounced state changes or
// when the link has been quiet for a heartbeat period.
module wall_report_scheduler #(
    parameter int DEBOUNCE_SAMPLES = 4,
    parameter int HEARTBEAT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] obst,
    input  logic       sample_tick,
    input  logic       tx_ready,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic [2:0] wall_state,
    output logic [7:0] frame_count
);

    localparam int              HB_W    = 20;
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(HEARTBEAT_CYCLES - 1);
    localparam logic [3:0]      DEB_N   = 4'(DEBOUNCE_SAMPLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [2:0]      cand;
    logic [3:0]      match_cnt;
    logic [HB_W-1:0] hb_cnt;
    logic            pending;
    logic            stable_change;
    logic            hb_fire;
    logic            accept;
    logic            launch;

    // Frame layout: duplicated parity bit, then the data sent twice.
    function automatic logic [7:0] encode(input logic [2:0] d);
        logic p;
        p = ^d;
        return {p, p, d, d};
    endfunction

    assign stable_change = (match_cnt >= DEB_N) && (cand != wall_state);
    assign hb_fire       = (hb_cnt == HB_LAST);
    assign accept        = tx_valid && tx_ready;
    assign launch        = (state == IDLE) && pending;
    assign tx_valid      = (state == SEND);

    // Track the latest candidate sample and how many ticks in a row it has held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand      <= 3'b000;
            match_cnt <= 4'd0;
        end else if (sample_tick) begin
            if (obst == cand) begin
                if (match_cnt != 4'hF)
                    match_cnt <= match_cnt + 4'd1;
            end else begin
                cand      <= obst;
                match_cnt <= 4'd1;
            end
        end
    end

    // Adopt the candidate once it has been stable long enough.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wall_state <= 3'b000;
        else if (stable_change)
            wall_state <= cand;
    end

    // Quiet-link timer: restarts on every accepted frame and on its own expiry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            hb_cnt <= '0;
        else if (accept || hb_fire)
            hb_cnt <= '0;
        else
            hb_cnt <= hb_cnt + HB_W'(1);
    end

    // Pending merges all report requests; a new request in the launch cycle
    // wins so a change landing then is not lost behind the outgoing frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pending <= 1'b0;
        else if (stable_change || hb_fire)
            pending <= 1'b1;
        else if (launch)
            pending <= 1'b0;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // FSM next-state: one frame in flight, then a single-cycle gap.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pending)  state_next = SEND;
            SEND:    if (tx_ready) state_next = GAP;
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Frame payload is captured from the live wall state when leaving IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tx_data <= 8'h00;
        else if (launch)
            tx_data <= encode(wall_state);
    end

    // Count frames taken by the transmitter; wraps naturally at 256.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            frame_count <= 8'd0;
        else if (accept)
            frame_count <= frame_count + 8'd1;
    end

endmodule

// File: tb/tb_wall_report_scheduler.sv
// Bench for wall_report_scheduler: vector table, directed corner sequences
// and a randomized run against a behavioural model.
module tb_wall_report_scheduler;

    localparam int DEB = 4;
    localparam int HB  = 1000;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] obst;
    logic       sample_tick;
    logic       tx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic [2:0] wall_state;
    logic [7:0] frame_count;

    int total  = 0;
    int bad    = 0;
    int cyc_no = 0;

    always #5 clk = ~clk;

    wall_report_scheduler #(.DEBOUNCE_SAMPLES(DEB), .HEARTBEAT_CYCLES(HB)) dut (
        .clk(clk), .reset(reset), .obst(obst), .sample_tick(sample_tick),
        .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
        .wall_state(wall_state), .frame_count(frame_count)
    );

    typedef struct {
        logic [2:0] obst;
        logic       tick;
        logic       ready;
        logic [2:0] wall;
        logic       valid;
        logic [7:0] data;
        logic [7:0] cnt;
    } vec_t;

    vec_t vt[18];

    function automatic logic [7:0] enc(input logic [2:0] d);
        logic p;
        p = d[0] ^ d[1] ^ d[2];
        return {p, p, d, d};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; everything is driven and sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    task automatic do_reset();
        reset = 1'b1; obst = 3'b000; sample_tick = 1'b0; tx_ready = 1'b0;
        cyc(); cyc();
        chk("rst_valid", tx_valid, 1'b0);
        chk("rst_data", tx_data, 8'h00);
        chk("rst_wall", wall_state, 3'b000);
        chk("rst_count", frame_count, 8'd0);
        reset = 1'b0;
    endtask

    task automatic ticks(input logic [2:0] v, input int n);
        for (int k = 0; k < n; k++) begin
            obst = v; sample_tick = 1'b1; cyc();
        end
        sample_tick = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int limit);
        int n;
        n = 0;
        while (!tx_valid && n < limit) begin cyc(); n++; end
        chk(name, tx_valid, 1'b1);
    endtask

    task automatic wait_accept(output int t, output logic [7:0] d, output logic ok);
        ok = 1'b0; t = 0; d = 8'h00;
        for (int k = 0; k < 2500; k++) begin
            if (tx_valid && tx_ready) begin
                d = tx_data; cyc(); t = cyc_no; ok = 1'b1;
                return;
            end
            cyc();
        end
    endtask

    initial begin
        logic [7:0] acc_q[4];
        int         n_acc;
        int         t0, t1, t2;
        logic [7:0] d0, d1, d2;
        logic       ok0, ok1, ok2;
        logic [2:0] m_wall, run_val, pw;
        int         run_len, m_cnt;
        logic       acc, prev_valid;
        logic [7:0] prev_data;

        reset = 1'b1; obst = 3'b000; sample_tick = 1'b0; tx_ready = 1'b0;

        // 011 for three ticks then 000: no frame. Then 010 over four ticks: one D2 frame.
        vt[0]  = '{3'b011, 1'b1, 1'b1, 3'b000, 1'b0, 8'h00, 8'd0};
        vt[1]  = '{3'b011, 1'b1, 1'b1, 3'b000, 1'b0, 8'h00, 8'd0};
        vt[2]  = '{3'b011, 1'b1, 1'b1, 3'b000, 1'b0, 8'h00, 8'd0};
        vt[3]  = '{3'b000, 1'b1, 1'b1, 3'b000, 1'b0, 8'h00, 8'd0};
        vt[4]  = '{3'b000, 1'b1, 1'b1, 3'b000, 1'b0, 8'h00, 8'd0};
        vt[5]  = '{3'b000, 1'b1, 1'b1, 3'b000, 1'b0, 8'h00, 8'd0};
        vt[6]  = '{3'b000, 1'b1, 1'b1, 3'b000, 1'b0, 8'h00, 8'd0};
        vt[7]  = '{3'b000, 1'b0, 1'b1, 3'b000, 1'b0, 8'h00, 8'd0};
        vt[8]  = '{3'b000, 1'b0, 1'b1, 3'b000, 1'b0, 8'h00, 8'd0};
        vt[9]  = '{3'b010, 1'b1, 1'b1, 3'b000, 1'b0, 8'h00, 8'd0};
        vt[10] = '{3'b010, 1'b1, 1'b1, 3'b000, 1'b0, 8'h00, 8'd0};
        vt[11] = '{3'b010, 1'b1, 1'b1, 3'b000, 1'b0, 8'h00, 8'd0};
        vt[12] = '{3'b010, 1'b1, 1'b1, 3'b000, 1'b0, 8'h00, 8'd0};
        vt[13] = '{3'b010, 1'b0, 1'b1, 3'b010, 1'b0, 8'h00, 8'd0};
        vt[14] = '{3'b010, 1'b0, 1'b1, 3'b010, 1'b1, 8'hD2, 8'd0};
        vt[15] = '{3'b010, 1'b0, 1'b1, 3'b010, 1'b0, 8'h00, 8'd1};
        vt[16] = '{3'b010, 1'b0, 1'b1, 3'b010, 1'b0, 8'h00, 8'd1};
        vt[17] = '{3'b010, 1'b0, 1'b1, 3'b010, 1'b0, 8'h00, 8'd1};

        do_reset();
        for (int i = 0; i < 18; i++) begin
            obst = vt[i].obst; sample_tick = vt[i].tick; tx_ready = vt[i].ready;
            cyc();
            chk($sformatf("vec%0d_wall", i), wall_state, vt[i].wall);
            chk($sformatf("vec%0d_valid", i), tx_valid, vt[i].valid);
            if (vt[i].valid) chk($sformatf("vec%0d_data", i), tx_data, vt[i].data);
            chk($sformatf("vec%0d_count", i), frame_count, vt[i].cnt);
        end
        sample_tick = 1'b0;

        // 111 with the transmitter stalled for 20 cycles.
        tx_ready = 1'b0;
        ticks(3'b111, 4);
        wait_valid("s31_valid_arrives", 20);
        for (int k = 0; k < 20; k++) begin
            cyc();
            chk($sformatf("s31_hold_valid%0d", k), tx_valid, 1'b1);
            chk($sformatf("s31_hold_data%0d", k), tx_data, 8'hFF);
        end
        tx_ready = 1'b1; cyc(); tx_ready = 1'b0;
        chk("s31_accept_valid", tx_valid, 1'b0);
        chk("s31_accept_count", frame_count, 8'd2);
        for (int k = 0; k < 10; k++) cyc();
        chk("s31_no_repeat", tx_valid, 1'b0);
        chk("s31_wall", wall_state, 3'b111);

        // 001 stalled in SEND while 100 gets debounced: C9 then E4, nothing else.
        ticks(3'b001, 4);
        wait_valid("s33_valid_arrives", 20);
        chk("s33_first_data", tx_data, 8'hC9);
        ticks(3'b100, 4);
        cyc(); cyc(); cyc();
        chk("s33_wall_moved", wall_state, 3'b100);
        chk("s33_still_c9", tx_data, 8'hC9);
        tx_ready = 1'b1;
        n_acc = 0;
        for (int k = 0; k < 4; k++) acc_q[k] = 8'h00;
        for (int k = 0; k < 12; k++) begin
            if (tx_valid) begin
                if (n_acc < 4) acc_q[n_acc] = tx_data;
                n_acc++;
            end
            cyc();
        end
        chk("s33_frames", n_acc, 2);
        chk("s33_frame0", acc_q[0], 8'hC9);
        chk("s33_frame1", acc_q[1], 8'hE4);
        chk("s33_count", frame_count, 8'd4);

        // Heartbeat: expiry sets pending, one cycle to launch, one to accept.
        wait_accept(t0, d0, ok0);
        wait_accept(t1, d1, ok1);
        wait_accept(t2, d2, ok2);
        chk("s32_seen", {ok0, ok1, ok2}, 3'b111);
        chk("s32_period1", t1 - t0, HB + 2);
        chk("s32_period2", t2 - t1, HB + 2);
        chk("s32_data", d1, 8'hE4);
        chk("s32_data2", d2, 8'hE4);

        // Reset pulse while a frame is stalled in SEND.
        tx_ready = 1'b0;
        ticks(3'b010, 4);
        wait_valid("s34_valid_arrives", 20);
        chk("s34_data", tx_data, 8'hD2);
        reset = 1'b1;
        #1;
        chk("s34_async_valid", tx_valid, 1'b0);
        chk("s34_async_count", frame_count, 8'd0);
        chk("s34_async_wall", wall_state, 3'b000);
        cyc();
        chk("s34_hold_valid", tx_valid, 1'b0);
        reset = 1'b0;
        tx_ready = 1'b1;
        n_acc = 0;
        for (int k = 0; k < 50; k++) begin
            cyc();
            if (tx_valid) n_acc++;
        end
        chk("s34_no_frame", n_acc, 0);
        chk("s34_count", frame_count, 8'd0);

        // Randomized run against a run-length model of the debouncer.
        do_reset();
        m_wall = 3'b000; run_val = 3'b000; run_len = 0; m_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 2) obst = 3'($urandom_range(0, 7));
            sample_tick = 1'($urandom_range(0, 1));
            tx_ready    = ($urandom_range(0, 3) != 0);
            acc        = tx_valid && tx_ready;
            prev_valid = tx_valid;
            prev_data  = tx_data;
            pw         = m_wall;
            if (run_len >= DEB && run_val != m_wall) m_wall = run_val;
            if (sample_tick) begin
                if (obst == run_val) run_len++;
                else begin run_val = obst; run_len = 1; end
            end
            if (acc) m_cnt++;
            cyc();
            chk($sformatf("rnd%0d_wall", i), wall_state, m_wall);
            chk($sformatf("rnd%0d_count", i), frame_count, m_cnt % 256);
            if (acc)
                chk($sformatf("rnd%0d_gap", i), tx_valid, 1'b0);
            else if (prev_valid) begin
                chk($sformatf("rnd%0d_hold", i), tx_valid, 1'b1);
                chk($sformatf("rnd%0d_stable", i), tx_data, prev_data);
            end else if (tx_valid)
                chk($sformatf("rnd%0d_launch", i), tx_data, enc(pw));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
